// File: rtl/fcims_pkg.sv
// Shared definitions for the FCIMS payment divider: default widths,
// response status codes and the controller state encoding.
// No logic lives here; the RTL modules import it.
package fcims_pkg;

   // Default datapath widths
   localparam int AMT_W   = 8;
   localparam int PRICE_W = 4;
   localparam int CT_W    = 4;

   // Response status codes
   typedef enum logic [1:0] {
      ST_OK         = 2'd0,
      ST_LIMITED    = 2'd1,
      ST_UNDERPAID  = 2'd2,
      ST_ZERO_PRICE = 2'd3
   } status_e;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_CLAMP = 2'd2,
      S_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/fcims_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, MSB first.
// Latency: loads on start, then AMT_W iteration cycles; done marks the last one.
// Backpressure: none; start is ignored while busy.
module fcims_serial_div #(
   parameter int AMT_W   = fcims_pkg::AMT_W,
   parameter int PRICE_W = fcims_pkg::PRICE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [AMT_W-1:0]   dividend,
   input  logic [PRICE_W-1:0] divisor,
   output logic               busy,
   output logic               done,
   output logic [AMT_W-1:0]   quotient,
   output logic [PRICE_W:0]   remainder
);
   import fcims_pkg::*;

   localparam logic [3:0] LAST_IT = 4'(AMT_W - 1);

   logic               busy_q, busy_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [AMT_W-1:0]   quo_q, quo_d;
   logic [PRICE_W:0]   rem_q, rem_d;
   logic [PRICE_W-1:0] dvs_q, dvs_d;
   logic [PRICE_W:0]   trial;

   // The quotient register doubles as the dividend shifter: its MSB feeds the
   // partial remainder and each new quotient bit enters at the LSB.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      trial  = {rem_q[PRICE_W-1:0], quo_q[AMT_W-1]};
      if (start && !busy_q) begin
         busy_d = 1'b1;
         cnt_d  = 4'd0;
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
      end else if (busy_q) begin
         if (trial >= {1'b0, dvs_q}) begin
            rem_d = trial - {1'b0, dvs_q};
            quo_d = {quo_q[AMT_W-2:0], 1'b1};
         end else begin
            rem_d = trial;
            quo_d = {quo_q[AMT_W-2:0], 1'b0};
         end
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == LAST_IT) begin
            busy_d = 1'b0;
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= 4'd0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign busy      = busy_q;
   assign done      = busy_q && (cnt_q == LAST_IT);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/fcims_payment_divider.sv
// Payment divider: amount / unit price -> cells dispensed (stock-clamped) and change.
// Latency: response AMT_W+2 cycles after accept, 1 cycle for a zero price.
// Backpressure: one request in flight; response held until resp_ready.
module fcims_payment_divider #(
   parameter int AMT_W   = fcims_pkg::AMT_W,
   parameter int PRICE_W = fcims_pkg::PRICE_W,
   parameter int CT_W    = fcims_pkg::CT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [AMT_W-1:0]   amount,
   input  logic [PRICE_W-1:0] uprice,
   input  logic               restock_valid,
   input  logic [CT_W-1:0]    restock_qty,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [CT_W-1:0]    ncel,
   output logic [AMT_W-1:0]   change,
   output logic [1:0]         status,
   output logic [CT_W-1:0]    stock
);
   import fcims_pkg::*;

   localparam logic [CT_W-1:0] CT_MAX = '1;

   state_e             state_q, state_d;
   logic [AMT_W-1:0]   amount_q, amount_d;
   logic [PRICE_W-1:0] price_q, price_d;
   logic [CT_W-1:0]    ncel_q, ncel_d;
   logic [AMT_W-1:0]   change_q, change_d;
   status_e            status_q, status_d;
   logic               resp_valid_q, resp_valid_d;
   logic [CT_W-1:0]    stock_q, stock_d;

   logic               div_start, div_busy, div_done;
   logic [AMT_W-1:0]   div_quot;
   logic [PRICE_W:0]   div_rem;

   logic [CT_W-1:0]    q_cap_c, ncel_c, deduct_c, add_c;
   logic [AMT_W-1:0]   change_c;
   status_e            status_c;
   logic [CT_W:0]      stock_sum_c;

   fcims_serial_div #(
      .AMT_W   (AMT_W),
      .PRICE_W (PRICE_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (amount),
      .divisor   (uprice),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   assign req_ready = (state_q == S_IDLE) && !div_busy;
   assign div_start = req_ready && req_valid && (uprice != '0);

   // Clamp the quotient to stock and count width; derive change and status.
   // When nothing was clamped the divider remainder already is the change.
   always_comb begin
      q_cap_c = (div_quot > AMT_W'(CT_MAX)) ? CT_MAX : div_quot[CT_W-1:0];
      ncel_c  = (q_cap_c < stock_q) ? q_cap_c : stock_q;
      if (AMT_W'(ncel_c) == div_quot) begin
         change_c = AMT_W'(div_rem);
      end else begin
         change_c = amount_q - (AMT_W'(ncel_c) * AMT_W'(price_q));
      end
      if (div_quot == '0) begin
         status_c = ST_UNDERPAID;
      end else if (AMT_W'(ncel_c) < div_quot) begin
         status_c = ST_LIMITED;
      end else begin
         status_c = ST_OK;
      end
   end

   // Stock: deduction only in CLAMP, restock any cycle, saturating at CT_MAX
   always_comb begin
      deduct_c    = (state_q == S_CLAMP) ? ncel_c : '0;
      add_c       = restock_valid ? restock_qty : '0;
      stock_sum_c = {1'b0, stock_q} - {1'b0, deduct_c} + {1'b0, add_c};
      stock_d     = (stock_sum_c > {1'b0, CT_MAX}) ? CT_MAX : stock_sum_c[CT_W-1:0];
   end

   // Request/response sequencing and registered result outputs
   always_comb begin
      state_d      = state_q;
      amount_d     = amount_q;
      price_d      = price_q;
      ncel_d       = ncel_q;
      change_d     = change_q;
      status_d     = status_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               amount_d = amount;
               price_d  = uprice;
               if (uprice == '0) begin
                  ncel_d       = '0;
                  change_d     = amount;
                  status_d     = ST_ZERO_PRICE;
                  resp_valid_d = 1'b1;
                  state_d      = S_RESP;
               end else begin
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            if (div_done) begin
               state_d = S_CLAMP;
            end
         end
         S_CLAMP: begin
            ncel_d       = ncel_c;
            change_d     = change_c;
            status_d     = status_c;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Controller, result and stock registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         amount_q     <= '0;
         price_q      <= '0;
         ncel_q       <= '0;
         change_q     <= '0;
         status_q     <= ST_OK;
         resp_valid_q <= 1'b0;
         stock_q      <= '0;
      end else begin
         state_q      <= state_d;
         amount_q     <= amount_d;
         price_q      <= price_d;
         ncel_q       <= ncel_d;
         change_q     <= change_d;
         status_q     <= status_d;
         resp_valid_q <= resp_valid_d;
         stock_q      <= stock_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign ncel       = ncel_q;
   assign change     = change_q;
   assign status     = status_q;
   assign stock      = stock_q;

endmodule

// File: tb/tb_fcims_payment_divider.sv
// Bench for fcims_payment_divider: directed cases plus randomized requests
// checked against an arithmetic model of dispensing, change and stock.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fcims_payment_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] amount;
   logic [3:0] uprice;
   logic       restock_valid;
   logic [3:0] restock_qty;
   logic       resp_valid;
   logic       resp_ready;
   logic [3:0] ncel;
   logic [7:0] change;
   logic [1:0] status;
   logic [3:0] stock;

   int tests = 0;
   int fails = 0;
   int mstock = 0;

   fcims_payment_divider dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .amount        (amount),
      .uprice        (uprice),
      .restock_valid (restock_valid),
      .restock_qty   (restock_qty),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .ncel          (ncel),
      .change        (change),
      .status        (status),
      .stock         (stock)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int sat15(input int x);
      return (x > 15) ? 15 : x;
   endfunction

   // Reference: plain integer division, then clamp by stock and the 4-bit count
   function automatic void ref_calc(input int amt, input int pr, input int st,
                                    output int n, output int ch, output int sts);
      int q;
      if (pr == 0) begin
         n = 0; ch = amt; sts = 3;
      end else begin
         q = amt / pr;
         n = q;
         if (n > st) n = st;
         if (n > 15) n = 15;
         ch = amt - n * pr;
         if (q == 0) sts = 2;
         else if (n < q) sts = 1;
         else sts = 0;
      end
   endfunction

   task automatic reset_dut;
      rst = 1'b1;
      step;
      rst = 1'b0;
      mstock = 0;
   endtask

   task automatic restock_pulse(input int qty);
      restock_valid = 1'b1;
      restock_qty   = 4'(qty);
      step;
      restock_valid = 1'b0;
      mstock = sat15(mstock + qty);
   endtask

   // Issue one request and wait (bounded) for resp_valid; optional restock at
   // cycle index rs_lat after acceptance. lat==40 means the wait expired.
   task automatic run_req(input int amt, input int pr, input int rs_lat, input int rs_qty,
                          output int lat, output bit rs_applied);
      req_valid = 1'b1;
      amount    = 8'(amt);
      uprice    = 4'(pr);
      step;
      req_valid  = 1'b0;
      lat        = 1;
      rs_applied = 1'b0;
      while (resp_valid !== 1'b1 && lat < 40) begin
         if (lat == rs_lat) begin
            restock_valid = 1'b1;
            restock_qty   = 4'(rs_qty);
            rs_applied    = 1'b1;
         end
         step;
         restock_valid = 1'b0;
         lat++;
      end
   endtask

   task automatic ack;
      resp_ready = 1'b1;
      step;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset_dut;
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stock !== 4'd0 ||
          ncel !== 4'd0 || change !== 8'd0 || status !== 2'd0) begin
         fails++;
         $display("FAIL reset: got rv=%b rr=%b stock=%0d ncel=%0d change=%0d status=%0d, want 0 1 0 0 0 0",
                  resp_valid, req_ready, stock, ncel, change, status);
      end
   endtask

   task automatic test_directed;
      // pre_stock, amount, uprice, rs_lat, rs_qty, ncel, change, status, latency, stock_after
      int tbl [5][10] = '{
         '{10,  37, 5, 0,  0,  7,   2, 0, 10,  3},
         '{15, 200, 3, 0,  0, 15, 155, 1, 10,  0},
         '{ 5,   4, 9, 0,  0,  0,   4, 2, 10,  5},
         '{ 0,  50, 0, 0,  0,  0,  50, 3,  1,  0},
         '{ 6,  20, 5, 9, 12,  4,   0, 0, 10, 14}
      };
      int lat;
      bit rsa;
      for (int i = 0; i < 5; i++) begin
         reset_dut;
         if (tbl[i][0] > 0) restock_pulse(tbl[i][0]);
         run_req(tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], lat, rsa);
         tests++;
         if (lat !== tbl[i][8] || ncel !== 4'(tbl[i][5]) || change !== 8'(tbl[i][6]) ||
             status !== 2'(tbl[i][7])) begin
            fails++;
            $display("FAIL directed%0d: got lat=%0d ncel=%0d change=%0d status=%0d, want %0d %0d %0d %0d",
                     i, lat, ncel, change, status, tbl[i][8], tbl[i][5], tbl[i][6], tbl[i][7]);
         end
         ack;
         tests++;
         if (stock !== 4'(tbl[i][9]) || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL directed%0d_stock: got stock=%0d rv=%b, want %0d 0",
                     i, stock, resp_valid, tbl[i][9]);
         end
      end
   endtask

   task automatic test_reset_mid_div;
      int lat, en, ec, es;
      bit rsa;
      logic [3:0] n0;
      logic [7:0] c0;
      logic [1:0] s0;
      reset_dut;
      restock_pulse(9);
      req_valid = 1'b1; amount = 8'd100; uprice = 4'd7;
      step;                       // accepted; now in DIV cycle 1
      req_valid = 1'b0;
      step; step; step;           // DIV cycle 4
      rst = 1'b1;
      step;
      rst = 1'b0;
      mstock = 0;
      tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || stock !== 4'd0) begin
         fails++;
         $display("FAIL reset_mid_div: got rr=%b rv=%b stock=%0d, want 1 0 0", req_ready, resp_valid, stock);
      end
      restock_pulse(8);
      run_req(100, 7, 0, 0, lat, rsa);
      ref_calc(100, 7, mstock, en, ec, es);
      mstock -= en;
      tests++;
      if (lat !== 10 || ncel !== 4'(en) || change !== 8'(ec) || status !== 2'(es)) begin
         fails++;
         $display("FAIL after_reset_req: got lat=%0d ncel=%0d change=%0d status=%0d, want 10 %0d %0d %0d",
                  lat, ncel, change, status, en, ec, es);
      end
      n0 = ncel; c0 = change; s0 = status;
      for (int k = 0; k < 5; k++) begin
         step;
         tests++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || ncel !== n0 || change !== c0 || status !== s0) begin
            fails++;
            $display("FAIL hold%0d: got rv=%b rr=%b ncel=%0d change=%0d status=%0d, want 1 0 %0d %0d %0d",
                     k, resp_valid, req_ready, ncel, change, status, n0, c0, s0);
         end
      end
      ack;
      tests++;
      if (stock !== 4'(mstock) || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL hold_release: got stock=%0d rv=%b rr=%b, want %0d 0 1", stock, resp_valid, req_ready, mstock);
      end
   endtask

   task automatic test_back_to_back;
      int amts [2] = '{90, 50};
      int prs  [2] = '{7, 4};
      int lat, en, ec, es;
      bit rsa;
      reset_dut;
      restock_pulse(15);
      for (int i = 0; i < 2; i++) begin
         run_req(amts[i], prs[i], 0, 0, lat, rsa);
         ref_calc(amts[i], prs[i], mstock, en, ec, es);
         mstock -= en;
         tests++;
         if (lat !== 10 || req_ready !== 1'b0 || ncel !== 4'(en) || change !== 8'(ec) || status !== 2'(es)) begin
            fails++;
            $display("FAIL b2b%0d: got lat=%0d rr=%b ncel=%0d change=%0d status=%0d, want 10 0 %0d %0d %0d",
                     i, lat, req_ready, ncel, change, status, en, ec, es);
         end
         ack;
         tests++;
         if (req_ready !== 1'b1 || stock !== 4'(mstock)) begin
            fails++;
            $display("FAIL b2b%0d_ready: got rr=%b stock=%0d, want 1 %0d", i, req_ready, stock, mstock);
         end
      end
   endtask

   task automatic test_random;
      int amt, pr, rs_lat, rs_qty, lat, en, ec, es, hold, exp_lat;
      bit rsa;
      reset_dut;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) restock_pulse($urandom_range(0, 15));
         amt    = $urandom_range(0, 255);
         pr     = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 15);
         rs_lat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0;
         rs_qty = $urandom_range(0, 15);
         run_req(amt, pr, rs_lat, rs_qty, lat, rsa);
         if (rsa && rs_lat < 9) mstock = sat15(mstock + rs_qty);
         ref_calc(amt, pr, mstock, en, ec, es);
         if (pr != 0) mstock -= en;
         if (rsa && rs_lat == 9) mstock = sat15(mstock + rs_qty);
         exp_lat = (pr == 0) ? 1 : 10;
         tests++;
         if (lat !== exp_lat || ncel !== 4'(en) || change !== 8'(ec) || status !== 2'(es)) begin
            fails++;
            $display("FAIL random%0d a=%0d p=%0d: got lat=%0d ncel=%0d change=%0d status=%0d, want %0d %0d %0d %0d",
                     it, amt, pr, lat, ncel, change, status, exp_lat, en, ec, es);
         end
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) begin
            if (k == 0 && $urandom_range(0, 1) == 1) restock_pulse($urandom_range(1, 15));
            else step;
         end
         tests++;
         if (resp_valid !== 1'b1 || ncel !== 4'(en) || change !== 8'(ec) || status !== 2'(es)) begin
            fails++;
            $display("FAIL random%0d_held: got rv=%b ncel=%0d change=%0d status=%0d, want 1 %0d %0d %0d",
                     it, resp_valid, ncel, change, status, en, ec, es);
         end
         ack;
         tests++;
         if (stock !== 4'(mstock) || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL random%0d_stock: got stock=%0d rv=%b, want %0d 0", it, stock, resp_valid, mstock);
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 1'b0;
      amount        = 8'd0;
      uprice        = 4'd0;
      restock_valid = 1'b0;
      restock_qty   = 4'd0;
      resp_ready    = 1'b0;
      step;
      test_reset;
      test_directed;
      test_reset_mid_div;
      test_back_to_back;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
